// File: rtl/riscv_mem_types_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mem_types_pkg
//   Shared types for the cache-to-memory request/response channel endpoint.
//   - mem_slave_state_e : response engine states (IDLE, WAIT, RESP)
//   - mem_slave_req_t   : one queued request as held in the request FIFO
//   - MEM_SLAVE_DEFAULT_LATENCY : default access-to-response latency
//   - MEM_SLAVE_ID_W    : width of the tag field carried in mem_slave_req_t
// ----------------------------------------------------------------------------
package riscv_mem_types_pkg;

    localparam int MEM_SLAVE_DEFAULT_LATENCY = 2;

    // Tag width stored in the queued entry; mem_slave_sram's ID_W defaults
    // to this value.
    localparam int MEM_SLAVE_ID_W = 4;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_RESP = 2'd2
    } mem_slave_state_e;

    typedef struct packed {
        logic [31:0]               addr;
        logic                      write;
        logic [31:0]               wdata;
        logic [3:0]                wstrb;
        logic [MEM_SLAVE_ID_W-1:0] id;
    } mem_slave_req_t;

endpackage

// File: rtl/mem_slave_req_fifo.sv
// ----------------------------------------------------------------------------
// mem_slave_req_fifo
//   Parameterized synchronous in-order FIFO with full/empty flags.
//   The head entry is visible on rdata_o whenever empty_o is low (no
//   fall-through: a word pushed at an edge is visible only after that edge).
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     push_i, wdata_i    write one entry (ignored when full)
//     pop_i              drop the head entry (ignored when empty)
//     rdata_o            head entry
//     full_o, empty_o    occupancy flags
//   Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2)
// ----------------------------------------------------------------------------
module mem_slave_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to distinguish full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] store_q [DEPTH];
    logic             push_eff;
    logic             pop_eff;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = store_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_eff = push_i && !full_o;
        pop_eff  = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_eff) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_eff)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_eff) store_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mem_slave_sram.sv
// ----------------------------------------------------------------------------
// mem_slave_sram
//   Single-port word memory responder for the cache-to-memory channel.
//   Requests are queued in order; the engine pops one, performs the array
//   access at the pop edge, and presents the response LATENCY edges later,
//   holding it until rsp_ready_i.
//
//   Optional feature macro: MEM_SLAVE_WRITE_ACK_EN
//     defined     : every write returns a response (rdata = 0)
//     not defined : writes are posted; no response is issued for them
//
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     req_valid_i / req_ready_o      request handshake
//     req_addr_i, req_write_i,
//     req_wdata_i, req_wstrb_i,
//     req_id_i                       request payload
//     rsp_valid_o / rsp_ready_i      response handshake
//     rsp_rdata_o, rsp_error_o,
//     rsp_id_o                       response payload
//
//   Handshake: a transfer happens on the rising clk edge where valid and
//   ready are both high; a valid source holds its payload until then.
//   req_ready_o depends only on queue occupancy and reset, never on
//   rsp_ready_i.
// ----------------------------------------------------------------------------
module mem_slave_sram
    import riscv_mem_types_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = MEM_SLAVE_DEFAULT_LATENCY,
    parameter int QDEPTH  = 4,
    parameter int ID_W    = MEM_SLAVE_ID_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     req_addr_i,
    input  logic            req_write_i,
    input  logic [31:0]     req_wdata_i,
    input  logic [3:0]      req_wstrb_i,
    input  logic [ID_W-1:0] req_id_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_rdata_o,
    output logic            rsp_error_o,
    output logic [ID_W-1:0] rsp_id_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    mem_slave_req_t push_req;
    mem_slave_req_t head_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    assign push_req = '{
        addr:  req_addr_i,
        write: req_write_i,
        wdata: req_wdata_i,
        wstrb: req_wstrb_i,
        id:    MEM_SLAVE_ID_W'(req_id_i)
    };

    // Ready is forced low during reset so nothing is accepted then.
    assign req_ready_o = rst_n && !fifo_full;
    assign push        = req_valid_i && req_ready_o;

    mem_slave_req_fifo #(
        .WIDTH ($bits(mem_slave_req_t)),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_req),
        .pop_i   (pop),
        .rdata_o (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] head_idx;
    logic             head_err;

    assign head_idx = head_req.addr[IDX_W+1:2];
    // DEPTH is a power of two, so "word index >= DEPTH" is any upper bit set.
    assign head_err = (head_req.addr[1:0] != 2'b00) ||
                      (head_req.addr[31:IDX_W+2] != '0);

    // ------------------------------------------------------------------
    // Array: per-byte-lane storage, not reset
    // ------------------------------------------------------------------
    logic [3:0][7:0] mem_q [DEPTH];
    logic            mem_we;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (head_req.wstrb[b]) mem_q[head_idx][b] <= head_req.wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response engine
    // ------------------------------------------------------------------
    mem_slave_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_error_q, rsp_error_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             can_pop;
    logic             needs_rsp;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        rsp_id_d    = rsp_id_q;
        pop         = 1'b0;
        mem_we      = 1'b0;
        needs_rsp   = 1'b0;

        // A pop happens from IDLE, or on the response handshake edge so that
        // back-to-back requests do not pass through IDLE.
        can_pop = !fifo_empty &&
                  ((state_q == MS_IDLE) || ((state_q == MS_RESP) && rsp_ready_i));

        case (state_q)
            MS_WAIT: begin
                if (cnt_q == '0) state_d = MS_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            MS_RESP: begin
                if (rsp_ready_i) state_d = MS_IDLE;
            end
            default: ;
        endcase

        if (can_pop) begin
            pop    = 1'b1;
            mem_we = head_req.write && !head_err;
`ifdef MEM_SLAVE_WRITE_ACK_EN
            needs_rsp = 1'b1;
`else
            // Posted writes commit and leave the engine free for the next pop.
            needs_rsp = !head_req.write;
`endif
            if (needs_rsp) begin
                state_d     = MS_WAIT;
                cnt_d       = CNT_W'(LATENCY - 1);
                rsp_rdata_d = (head_req.write || head_err) ? 32'h0 : mem_q[head_idx];
                rsp_error_d = head_err;
                rsp_id_d    = ID_W'(head_req.id);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MS_IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid_o = (state_q == MS_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_mem_slave_sram.sv
// ----------------------------------------------------------------------------
// tb_mem_slave_sram
//   Directed bench for mem_slave_sram (DEPTH=1024, LATENCY=2, QDEPTH=4,
//   ID_W=4). Drivers push the hand-computed expected response into exp_q at
//   request acceptance; an independent monitor pops and compares on every
//   response handshake. Works with and without MEM_SLAVE_WRITE_ACK_EN.
// ----------------------------------------------------------------------------
module tb_mem_slave_sram;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int QDEPTH  = 4;
    localparam int ID_W    = 4;
    localparam int EW      = 32 + 1 + ID_W;

`ifdef MEM_SLAVE_WRITE_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [31:0]     req_addr_i;
    logic            req_write_i;
    logic [31:0]     req_wdata_i;
    logic [3:0]      req_wstrb_i;
    logic [ID_W-1:0] req_id_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [31:0]     rsp_rdata_o;
    logic            rsp_error_o;
    logic [ID_W-1:0] rsp_id_o;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            n_vec;
    int            n_bad;

    mem_slave_sram #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .QDEPTH  (QDEPTH),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .req_id_i    (req_id_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .rsp_id_o    (rsp_id_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b id=%0d expected none",
                         rsp_rdata_o, rsp_error_o, rsp_id_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp{rdata,err,id}", 64'({rsp_rdata_o, rsp_error_o, rsp_id_o}), 64'(mon_e));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [ID_W-1:0] id,
                        input logic exp_rsp, input logic [31:0] exp_rdata, input logic exp_err);
        logic acc;
        int   budget;
        acc         = 1'b0;
        budget      = 0;
        req_addr_i  = addr;
        req_write_i = wr;
        req_wdata_i = wdata;
        req_wstrb_i = strb;
        req_id_i    = id;
        req_valid_i = 1'b1;
        while (!acc && budget < 200) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc = 1'b1;
                if (exp_rsp) exp_q.push_back({exp_rdata, exp_err, id});
            end
            @(posedge clk);
            #1;
            budget++;
        end
        req_valid_i = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_accept: got no accept expected accept (addr %h)", addr);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [ID_W-1:0] id,
                           input logic [31:0] exp_rdata, input logic exp_err);
        send(addr, 1'b0, 32'h0, 4'h0, id, 1'b1, exp_rdata, exp_err);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [ID_W-1:0] id,
                            input logic exp_err);
        send(addr, 1'b1, wdata, strb, id, WR_ACK, 32'h0, exp_err);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || rsp_valid_o) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0 || rsp_valid_o) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        req_id_i    = '0;
        rsp_ready_i = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error_o), 64'd0);
        chk("rst_rsp_id",    64'(rsp_id_o),    64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Full write then read, with response latency from acceptance
        do_write(32'h0, 32'hDEADBEEF, 4'hF, 4'd3, 1'b0);
        drain();
        do_read(32'h0, 4'd5, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < LATENCY + 1; i++) begin
            @(negedge clk);
            chk("latency_not_yet", 64'(rsp_valid_o), 64'd0);
        end
        @(negedge clk);
        chk("latency_valid", 64'(rsp_valid_o), 64'd1);
        drain();

        // Partial byte-lane write
        do_write(32'h40, 32'h11223344, 4'hF, 4'd1, 1'b0);
        do_write(32'h40, 32'hCAFEBABE, 4'b0101, 4'd2, 1'b0);
        do_read(32'h40, 4'd6, 32'h11FE33BE, 1'b0);
        drain();

        // Errors: misaligned, out of range, suppressed write
        do_read(32'h2, 4'd7, 32'h0, 1'b1);
        do_read(32'h1000, 4'd8, 32'h0, 1'b1);
        do_write(32'h1000, 32'h12345678, 4'hF, 4'd9, 1'b1);
        do_read(32'h0, 4'd10, 32'hDEADBEEF, 1'b0);
        drain();

        // Zero-strobe write is legal and changes nothing
        do_write(32'h40, 32'hFFFFFFFF, 4'h0, 4'd11, 1'b0);
        do_read(32'h40, 4'd12, 32'h11FE33BE, 1'b0);
        drain();

        // Back-pressure: engine holds one, queue takes QDEPTH more
        rsp_ready_i = 1'b0;
        for (int i = 0; i < QDEPTH + 1; i++) begin
            do_read((i % 2 == 0) ? 32'h0 : 32'h40, ID_W'(i),
                    (i % 2 == 0) ? 32'hDEADBEEF : 32'h11FE33BE, 1'b0);
        end
        @(negedge clk);
        chk("full_req_ready", 64'(req_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
            chk("stall_rsp_id", 64'(rsp_id_o), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        drain();

        // Reset in WAIT with two requests queued
        do_read(32'h0, 4'd1, 32'hDEADBEEF, 1'b0);
        do_read(32'h0, 4'd2, 32'hDEADBEEF, 1'b0);
        do_read(32'h0, 4'd3, 32'hDEADBEEF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_req_ready", 64'(req_ready_o), 64'd1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;

        // Posted vs acknowledged write followed by read
        do_write(32'h8, 32'hA5A5A5A5, 4'hF, 4'd13, 1'b0);
        do_read(32'h8, 4'd14, 32'hA5A5A5A5, 1'b0);
        drain();
        repeat (10) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_slave_sram.md
# mem_slave_sram

Synthesizable single-port memory responder: the target-side endpoint of the core's cache-to-memory request/response channel. Accepts word read/write requests from an L1 cache (or any initiator) through a valid/ready request port, queues them in order, performs the array access, and returns responses after a fixed configurable latency. It is used as on-chip backing memory in FPGA builds and as the standard memory endpoint in cache-level testbenches.

## Interface
- DEPTH, 1024: array size in 32-bit words; power of two.
- LATENCY, 2: cycles from access start to response valid; ≥1.
- QDEPTH, 4: request queue entries; power of two, ≥2.
- ID_W, 4: request/response tag width.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_addr_i  in  32  byte address
- req_write_i  in  1  1 = write
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte enables (writes only)
- req_id_i  in  ID_W  tag echoed in response
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  32  read data; 0 for writes and errors
- rsp_error_o  out  1  access error
- rsp_id_o  out  ID_W  tag of the request being answered

## Operation
- Reset values: req_ready_o=0 while rst_n low, 1 after release (queue empty); rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, rsp_id_o=0; queue empty; state IDLE; counter 0. Array contents are not reset.
- Queue: in-order FIFO; req_ready_o = !full, with no combinational path from rsp_ready_i. There is no fall-through. A push at full cannot occur. Simultaneous push and pop is allowed at any occupancy.
- Engine FSM, states IDLE, WAIT, RESP:
  - IDLE: if the queue is non-empty, pop the head and perform the access at that edge. Go to WAIT, counter = LATENCY-1.
  - WAIT: decrement the counter. At counter==0 the next edge moves to RESP and asserts rsp_valid_o.
  - RESP: all rsp_* outputs are held stable until rsp_ready_i. On the handshake edge, if the queue is non-empty, pop and access immediately and go to WAIT (back-to-back). Otherwise go to IDLE with rsp_valid_o=0.
- Access: word index = addr[log2(DEPTH)+1:2].
  - Write: commits byte lanes selected by wstrb at pop time.
  - Read: captures the array word at pop time.
  - Ordering: a read popped after a write to the same word returns the new data.
- Error: addr[1:0]!=0 or addr[31:2] ≥ DEPTH gives rsp_error_o=1 and rsp_rdata_o=0. The write is suppressed and the array is unchanged.
- A write with wstrb=0 is legal: no array change, error=0.

## Timing
- Empty pipeline, accept at edge N: pop/access at N+1, rsp_valid_o high after edge N+1+LATENCY (LATENCY=2 gives N+3).
- With rsp_ready_i held high and the queue kept non-empty, throughput is one response per LATENCY+1 cycles.
- rsp_ready_i low stalls the engine in RESP. The queue keeps accepting requests until full.
- Reset asserted mid-operation: all in-flight and queued requests are discarded and outputs return to reset values asynchronously. A write already popped has committed; a queued write has not.

## Configuration
- MEM_SLAVE_WRITE_ACK_EN defined: every write produces a response (rdata=0, error per the rules above), identical in flow to reads.
- Not defined: writes are posted. A popped write commits and the FSM stays in IDLE, so the next pop can occur on the following edge. No response is issued for writes, including erroneous ones, which are silently dropped. Reads are unchanged.

## Structure
- riscv_mem_types_pkg holds:
  - mem_slave_state_e (IDLE, WAIT, RESP)
  - the queued-entry struct mem_slave_req_t (addr, write, wdata, wstrb, id)
  - MEM_SLAVE_DEFAULT_LATENCY
- One sub-module: mem_slave_req_fifo, a parameterized synchronous FIFO (width, depth) with full/empty flags.
- The array is a plain per-byte-lane register array so it infers RAM.

## Test plan
- Write 0xDEADBEEF to 0x0 (wstrb 1111, id 3), then read 0x0 (id 5) → write response id=3 error=0 (ACK_EN); read response rdata=0xDEADBEEF id=5, valid exactly LATENCY+1 cycles after acceptance.
- Write 0xCAFEBABE to 0x40 with wstrb 0101 over existing 0x11223344 → read 0x40 returns 0x11FE33BE.
- Read 0x2 (misaligned) and 0x1000 (DEPTH=1024, out of range); write 0x1000 → error=1, rdata=0; a later read of 0x0 is unchanged.
- Hold rsp_ready_i low and issue 5 requests → req_ready_o drops after the queue fills (QDEPTH+1 accepted, including the one in the engine). Release → responses drain in order with ids 0..4.
- Assert rst_n low while in WAIT with 2 queued → rsp_valid_o=0 and req_ready_o=0 immediately. After release req_ready_o=1 and no stale response appears.
- Without MEM_SLAVE_WRITE_ACK_EN: write 0xA5A5A5A5 to 0x8, then read 0x8 → only one response (the read, rdata=0xA5A5A5A5).
